// File: rtl/accel_rotator.sv
// accel_rotator: rotates the (X,Y) accelerometer vector about Z by a binary angle.
// Exact quadrant pre-rotation, NIT CORDIC micro-rotations, then a combined
// residual-angle correction and CORDIC gain compensation. Z passes through.
module accel_rotator #(
    parameter int unsigned DW  = 16,
    parameter int unsigned OW  = 32,
    parameter int unsigned AW  = 9,
    parameter int unsigned NIT = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic signed [DW-1:0] AcX,
    input  logic signed [DW-1:0] AcY,
    input  logic signed [DW-1:0] AcZ,
    input  logic        [AW-1:0] Theta,
    output logic signed [OW-1:0] XAc,
    output logic signed [OW-1:0] YAc,
    output logic signed [OW-1:0] ZAc,
    output logic                 Busy,
    output logic                 Valid
);

    // x/y carry GB fraction bits so per-iteration truncation stays well below 1 LSB
    localparam int unsigned GB  = 6;
    localparam int unsigned XW  = DW + 3 + GB;
    // residual angle is held in radians with FB fraction bits
    localparam int unsigned FB  = 24;
    localparam int unsigned RW  = FB + 3;
    localparam int unsigned IW  = (NIT > 1) ? $clog2(NIT) : 1;
    localparam int unsigned LW  = AW - 2;
    // pi * 2^29, used to turn the in-quadrant binary angle into radians
    localparam int unsigned PW  = 31;
    localparam int unsigned PRW = LW + PW;
    localparam int unsigned PSH = 29 + AW - 1 - FB;
    localparam logic [PW-1:0]  PI_Q29   = 31'd1686629713;
    localparam logic [PRW-1:0] ANG_HALF = PRW'(1) << (PSH - 1);
    // gain compensation K = round(0.607252935 * 2^16)
    localparam int unsigned KS  = 16;
    localparam int unsigned KW  = 17;
    localparam logic signed [KW-1:0] K_GAIN = KW'(39797);
    localparam int unsigned MW  = RW + XW;
    localparam int unsigned CW  = XW + 1;
    localparam int unsigned SW  = CW + KW;
    localparam logic signed [SW-1:0] S_HALF = SW'(1) <<< (KS + GB - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        SCALE,
        DONE
    } state_t;

    state_t state, state_next;

    logic signed [DW-1:0] ax_r, ay_r, az_r;
    logic        [AW-1:0] th_r;
    logic signed [XW-1:0] x_r, y_r;
    logic signed [RW-1:0] r_r;
    logic        [IW-1:0] cnt_r;

    logic signed [XW-1:0] ax_e_c, ay_e_c, x0_c, y0_c;
    logic        [PRW-1:0] ang_prod_c;
    logic signed [RW-1:0] r0_c, atan_c;
    logic signed [XW-1:0] x_sh_c, y_sh_c, x_it_c, y_it_c;
    logic signed [RW-1:0] r_it_c;
    logic signed [MW-1:0] ry_c, rx_c;
    logic signed [CW-1:0] xc_c, yc_c;
    logic signed [SW-1:0] px_c, py_c;
    logic signed [OW-1:0] xs_c, ys_c;

    // atan(2^-i) in radians: Q30 source table rounded to FB fraction bits
    function automatic logic signed [RW-1:0] atan_lut(input logic [3:0] idx);
        logic [31:0] q30;
        q30 = 32'd0;
        case (idx)
            4'd0:  q30 = 32'h3243_F6A9;
            4'd1:  q30 = 32'h1DAC_6705;
            4'd2:  q30 = 32'h0FAD_BAFD;
            4'd3:  q30 = 32'h07F5_6EA7;
            4'd4:  q30 = 32'h03FE_AB77;
            4'd5:  q30 = 32'h01FF_D55C;
            4'd6:  q30 = 32'h00FF_FAAB;
            4'd7:  q30 = 32'h007F_FF55;
            4'd8:  q30 = 32'h003F_FFEB;
            4'd9:  q30 = 32'h001F_FFFD;
            4'd10: q30 = 32'h0010_0000;
            4'd11: q30 = 32'h0008_0000;
            4'd12: q30 = 32'h0004_0000;
            4'd13: q30 = 32'h0002_0000;
            4'd14: q30 = 32'h0001_0000;
            4'd15: q30 = 32'h0000_8000;
        endcase
        return RW'((q30 + (32'd1 << (29 - FB))) >> (30 - FB));
    endfunction

    // quadrant pre-rotation and residual angle in radians
    assign ax_e_c     = XW'(ax_r) <<< GB;
    assign ay_e_c     = XW'(ay_r) <<< GB;
    assign ang_prod_c = PRW'(th_r[LW-1:0]) * PRW'(PI_Q29);
    assign r0_c       = RW'((ang_prod_c + ANG_HALF) >> PSH);

    always_comb begin
        x0_c = ax_e_c;
        y0_c = ay_e_c;
        case (th_r[AW-1 -: 2])
            2'd0: begin x0_c = ax_e_c;  y0_c = ay_e_c;  end
            2'd1: begin x0_c = -ay_e_c; y0_c = ax_e_c;  end
            2'd2: begin x0_c = -ax_e_c; y0_c = -ay_e_c; end
            2'd3: begin x0_c = ay_e_c;  y0_c = -ax_e_c; end
        endcase
    end

    // one CORDIC micro-rotation, direction from the residual sign
    assign atan_c = atan_lut(4'(cnt_r));
    assign x_sh_c = x_r >>> cnt_r;
    assign y_sh_c = y_r >>> cnt_r;

    always_comb begin
        x_it_c = x_r - y_sh_c;
        y_it_c = y_r + x_sh_c;
        r_it_c = r_r - atan_c;
        if (r_r[RW-1]) begin
            x_it_c = x_r + y_sh_c;
            y_it_c = y_r - x_sh_c;
            r_it_c = r_r + atan_c;
        end
    end

    // remove leftover residual with a small-angle rotation, then apply K and round
    assign ry_c = MW'(r_r) * MW'(y_r);
    assign rx_c = MW'(r_r) * MW'(x_r);
    assign xc_c = CW'(x_r) - CW'(ry_c >>> FB);
    assign yc_c = CW'(y_r) + CW'(rx_c >>> FB);
    assign px_c = SW'(xc_c) * SW'(K_GAIN);
    assign py_c = SW'(yc_c) * SW'(K_GAIN);
    assign xs_c = OW'((px_c + S_HALF) >>> (KS + GB));
    assign ys_c = OW'((py_c + S_HALF) >>> (KS + GB));

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = LOAD;
            LOAD:    state_next = ITER;
            ITER:    if (cnt_r == IW'(NIT - 1)) state_next = SCALE;
            SCALE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ax_r  <= '0;
            ay_r  <= '0;
            az_r  <= '0;
            th_r  <= '0;
            x_r   <= '0;
            y_r   <= '0;
            r_r   <= '0;
            cnt_r <= '0;
            XAc   <= '0;
            YAc   <= '0;
            ZAc   <= '0;
            Busy  <= 1'b0;
            Valid <= 1'b0;
        end else begin
            Busy  <= (state_next != IDLE);
            Valid <= (state == SCALE);
            case (state)
                IDLE: begin
                    if (enable) begin
                        ax_r <= AcX;
                        ay_r <= AcY;
                        az_r <= AcZ;
                        th_r <= Theta;
                    end
                end
                LOAD: begin
                    x_r   <= x0_c;
                    y_r   <= y0_c;
                    r_r   <= r0_c;
                    cnt_r <= '0;
                end
                ITER: begin
                    x_r   <= x_it_c;
                    y_r   <= y_it_c;
                    r_r   <= r_it_c;
                    cnt_r <= cnt_r + IW'(1);
                end
                SCALE: begin
                    XAc <= xs_c;
                    YAc <= ys_c;
                    ZAc <= OW'(az_r);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/accel_rotator.md
ACCEL_ROTATOR -- requirements
Module: accel_rotator

Interface
REQ-001 Parameter DW, 16, signed input sample width (8..24).
REQ-002 Parameter OW, 32, signed output width; OW >= DW+2.
REQ-003 Parameter AW, 9, angle width; binary angle, full circle = 2^AW.
REQ-004 Parameter NIT, 14, CORDIC iterations (8..16).
REQ-005 The block has one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 enable  in  1  start request, sampled in IDLE only.
REQ-009 AcX, AcY, AcZ  in  DW each  signed accelerometer axes, two's complement.
REQ-010 Theta  in  AW  rotation angle about Z; 0 = 0 deg, 2^(AW-2) = 90 deg.
REQ-011 XAc, YAc, ZAc  out  OW each  signed rotated axes.
REQ-012 Busy  out  1  high while a transform is in progress.
REQ-013 Valid  out  1  one-cycle pulse when XAc/YAc/ZAc update.

Function
REQ-014 Transform: XAc = AcX*cos(T) - AcY*sin(T); YAc = AcX*sin(T) + AcY*cos(T); ZAc = AcZ sign-extended.
REQ-015 States: IDLE, LOAD, ITER, SCALE, DONE; one state per cycle except ITER.
REQ-016 IDLE: enable=1 -> capture AcX, AcY, AcZ, Theta into internal registers; go to LOAD.
REQ-017 LOAD: exact quadrant pre-rotation from Theta[AW-1:AW-2] (0: x,y; 1: -y,x; 2: -x,-y; 3: y,-x); residual angle = Theta low AW-2 bits, in [0,90) deg.
REQ-018 Datapath x/y width DW+3 during pre-rotation and ITER; angle accumulator AW+2 bits.
REQ-019 ITER: NIT cycles, iteration i: d = sign of residual; x -= d*(y>>>i), y += d*(x>>>i), residual -= d*atan(2^-i); arithmetic shifts, all updates from previous-cycle values.
REQ-020 atan(2^-i) constants: 16-entry table scaled to 2^(AW+2) per circle, round-to-nearest.
REQ-021 SCALE: multiply x and y by K = round(0.607252935*2^16) = 39797, arithmetic shift right 16, round half up.
REQ-022 DONE: register results sign-extended to OW into XAc/YAc/ZAc; Valid=1 for this cycle only; next state IDLE.
REQ-023 Latency: enable sampled at edge E -> Valid high in cycle E+NIT+3 (17 cycles for NIT=14).
REQ-024 Busy = 1 in LOAD, ITER, SCALE, DONE; 0 in IDLE.
REQ-025 enable while Busy=1 is ignored; input changes after capture have no effect on the current transform.
REQ-026 enable held high: a new transform starts in the IDLE cycle after DONE; back-to-back throughput one result per NIT+4 cycles.
REQ-027 Outputs XAc/YAc/ZAc hold their last value until the next DONE.
REQ-028 Accuracy: |error| <= 2 LSB per axis vs ideal rounded result, for all inputs including -2^(DW-1).
REQ-029 No overflow is possible given REQ-002 and REQ-018; no saturation logic.

Reset
REQ-030 rst=0 asynchronously forces state IDLE, XAc=YAc=ZAc=0, Busy=0, Valid=0, clears internal registers.
REQ-031 rst asserted mid-transform aborts it; no Valid pulse is produced for the aborted transform.
REQ-032 First enable is honoured on the first rising edge with rst=1.

Verification
REQ-033 AcX=1000, AcY=527, AcZ=0, Theta=64 (45 deg), enable pulse -> Valid at 17th cycle; XAc=334+-2, YAc=1080+-2, ZAc=0.
REQ-034 AcX=1000, AcY=0, AcZ=-300, Theta=128 (90 deg) -> XAc=0+-2, YAc=1000+-2, ZAc=-300 (0xFFFFFED4).
REQ-035 AcX=AcY=-32768, Theta=64 -> XAc=0+-2, YAc=-46341+-2; no wrap.
REQ-036 enable re-pulsed in the 5th Busy cycle with different inputs -> ignored; outputs match the first inputs; exactly one Valid.
REQ-037 rst dropped to 0 at ITER cycle 6 -> Busy, Valid, outputs are 0 immediately; rst=1 plus enable -> full 17-cycle transform with correct results.
REQ-038 Sweep Theta over all 512 values with AcX=20000, AcY=-12000 -> every result within 2 LSB of the double-precision reference model.
